// File: rtl/flash_part_pkg.sv
// rtl/flash_part_pkg.sv - shared encodings for the partitioned flash array
// Contents: command opcodes, response status codes, FSM state codes, erased fill value.
package flash_part_pkg;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_OK           = 2'b00;
    localparam logic [1:0] ST_NOT_PROG     = 2'b01;
    localparam logic [1:0] ST_ALREADY_PROG = 2'b10;
    localparam logic [1:0] ST_BAD_CMD      = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_WRITE = 3'd2;
    localparam state_t S_ERASE = 3'd3;
    localparam state_t S_ERR   = 3'd4;

    // Erased flash reads as all ones; replicate this bit to the word width.
    localparam logic ERASED_WORD = 1'b1;

endpackage

// File: rtl/flash_page_eraser.sv
// rtl/flash_page_eraser.sv - page-walk counter for page erase
// Ports: clk/rst (async, active-high); en high while erasing;
//        idx = word offset within the page cleared this cycle; done = last word this cycle.
module flash_page_eraser #(
    parameter int PAGE_SZ = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] idx,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign idx  = cnt;
    assign done = en && (cnt == CNT_W'(PAGE_SZ - 1));

    // Counter parks at 0 whenever idle so every erase starts at the page base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_part_array.sv
// rtl/flash_part_array.sv - partitioned flash-style storage array with programmed bitmap
// Ports: clk/rst (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_pid/cmd_addr/cmd_wdata
//        command channel; rsp_valid/rsp_rdata/rsp_status one-cycle response; busy = !cmd_ready;
//        erase_cnt = wear count of the page just erased.
// Build option: define ERASE_CNT_EN to instantiate per-(pid,page) saturating erase counters.
module flash_part_array #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PID_CNT = 5,
    parameter int PID_W   = 4,
    parameter int PAGE_SZ = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PID_W-1:0]  cmd_pid,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic              busy,
    output logic [15:0]       erase_cnt
);
    import flash_part_pkg::*;

    localparam int DEPTH = PID_CNT * (1 << ADDR_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PG_W  = $clog2(PAGE_SZ);
    localparam int CNT_W = (PG_W > 0) ? PG_W : 1;
    localparam logic [PID_W:0] PID_LIM = (PID_W + 1)'(PID_CNT);

    state_t            state;
    logic [PID_W-1:0]  lat_pid;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  prog;

    logic [CNT_W-1:0]  pg_idx;
    logic              pg_done;
    logic [ADDR_W-1:0] erase_addr;
    logic [IDX_W-1:0]  cmd_idx;
    logic [IDX_W-1:0]  erase_idx;
    logic              accept;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    // {pid, addr} equals pid*2^ADDR_W + addr; legal pids keep it below DEPTH.
    assign cmd_idx    = IDX_W'({lat_pid, lat_addr});
    assign erase_addr = (lat_addr & ~ADDR_W'(PAGE_SZ - 1)) | ADDR_W'(pg_idx);
    assign erase_idx  = IDX_W'({lat_pid, erase_addr});

    flash_page_eraser #(
        .PAGE_SZ (PAGE_SZ),
        .CNT_W   (CNT_W)
    ) u_eraser (
        .clk  (clk),
        .rst  (rst),
        .en   (state == S_ERASE),
        .idx  (pg_idx),
        .done (pg_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lat_pid    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            prog       <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_pid   <= cmd_pid;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        if (({1'b0, cmd_pid} >= PID_LIM) || (cmd_op == OP_ILLEGAL)) begin
                            state <= S_ERR;
                        end else if (cmd_op == OP_READ) begin
                            state <= S_READ;
                        end else if (cmd_op == OP_WRITE) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_ERASE;
                        end
                    end
                end
                S_READ: begin
                    rsp_valid <= 1'b1;
                    state     <= S_IDLE;
                    if (prog[cmd_idx]) begin
                        rsp_rdata  <= mem[cmd_idx];
                        rsp_status <= ST_OK;
                    end else begin
                        rsp_rdata  <= {DATA_W{ERASED_WORD}};
                        rsp_status <= ST_NOT_PROG;
                    end
                end
                S_WRITE: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= S_IDLE;
                    if (prog[cmd_idx]) begin
                        rsp_status <= ST_ALREADY_PROG;
                    end else begin
                        prog[cmd_idx] <= 1'b1;
                        rsp_status    <= ST_OK;
                    end
                end
                S_ERASE: begin
                    prog[erase_idx] <= 1'b0;
                    if (pg_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_status <= ST_OK;
                        state      <= S_IDLE;
                    end
                end
                S_ERR: begin
                    rsp_valid  <= 1'b1;
                    rsp_rdata  <= '0;
                    rsp_status <= ST_BAD_CMD;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data RAM carries no reset; the bitmap alone decides what reads as programmed.
    always_ff @(posedge clk) begin
        if (state == S_WRITE && !prog[cmd_idx]) begin
            mem[cmd_idx] <= lat_wdata;
        end else if (state == S_ERASE) begin
            mem[erase_idx] <= {DATA_W{ERASED_WORD}};
        end
    end

`ifdef ERASE_CNT_EN
    localparam int PAGES = (1 << ADDR_W) / PAGE_SZ;
    localparam int EC_N  = PID_CNT * PAGES;
    localparam int EC_W  = (EC_N > 1) ? $clog2(EC_N) : 1;

    logic [15:0]     ecnt [EC_N];
    logic [15:0]     ec_next;
    logic [15:0]     erase_cnt_r;
    logic [EC_W-1:0] ec_idx;

    // {pid, addr} >> PG_W is pid*PAGES + page number.
    assign ec_idx    = EC_W'({lat_pid, lat_addr} >> PG_W);
    assign ec_next   = (ecnt[ec_idx] == 16'hFFFF) ? 16'hFFFF : ecnt[ec_idx] + 16'd1;
    assign erase_cnt = erase_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EC_N; i++) begin
                ecnt[i] <= 16'd0;
            end
            erase_cnt_r <= 16'd0;
        end else if (state == S_ERASE && pg_done) begin
            ecnt[ec_idx] <= ec_next;
            erase_cnt_r  <= ec_next;
        end
    end
`else
    assign erase_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_flash_part_array.sv
// tb/tb_flash_part_array.sv - directed self-checking bench for flash_part_array
module tb_flash_part_array;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_pid;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [15:0] erase_cnt;

    int checks;
    int errors;

    flash_part_array dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_pid    (cmd_pid),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .busy       (busy),
        .erase_cnt  (erase_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one command from posedge+1; returns at posedge+1 of the response cycle.
    // lat = edges after the accept edge until rsp_valid is seen (-1 on timeout).
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] pid, input logic [7:0] addr,
                          input logic [7:0] wd, output logic [7:0] rd, output logic [1:0] st,
                          output int lat, output int busy_cyc);
        cmd_op = op; cmd_pid = pid; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1; busy_cyc = 0;
        if (busy) busy_cyc++;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (rsp_valid) begin
                lat = e;
                break;
            end
        end
        rd = rsp_rdata; st = rsp_status;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_pid = 4'd0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL reset_rsp_status: got %b want 00", rsp_status); end
        checks++; if (erase_cnt !== 16'h0000) begin errors++; $display("FAIL reset_erase_cnt: got %h want 0000", erase_cnt); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_erased();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        do_cmd(2'b00, 4'd0, 8'h10, 8'h00, rd, st, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rd_erased_latency: got %0d want 1", lat); end
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL rd_erased_status: got %b want 01", st); end
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL rd_erased_data: got %h want ff", rd); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_valid_one_cycle: got %b want 0", rsp_valid); end
        checks++; if (rsp_status !== 2'b01) begin errors++; $display("FAIL rsp_status_hold: got %b want 01", rsp_status); end
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        do_cmd(2'b01, 4'd2, 8'h35, 8'hA5, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL wr_status: got %b want 00", st); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wr_rdata: got %h want 00", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d want 1", lat); end
        do_cmd(2'b00, 4'd2, 8'h35, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL rd_prog_status: got %b want 00", st); end
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd_prog_data: got %h want a5", rd); end
        do_cmd(2'b00, 4'd3, 8'h35, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL pid3_isolation_status: got %b want 01", st); end
        do_cmd(2'b01, 4'd4, 8'hFF, 8'h5A, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL wr_last_word_status: got %b want 00", st); end
        do_cmd(2'b00, 4'd4, 8'hFF, 8'h00, rd, st, lat, bc);
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL rd_last_word_data: got %h want 5a", rd); end
    endtask

    task automatic test_double_write();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        do_cmd(2'b01, 4'd2, 8'h35, 8'h3C, rd, st, lat, bc);
        checks++; if (st !== 2'b10) begin errors++; $display("FAIL rewrite_status: got %b want 10", st); end
        do_cmd(2'b00, 4'd2, 8'h35, 8'h00, rd, st, lat, bc);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rewrite_keeps_data: got %h want a5", rd); end
    endtask

    task automatic test_erase();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        logic [15:0] exp1; logic [15:0] exp2;
        logic [7:0] in_page [3];
`ifdef ERASE_CNT_EN
        exp1 = 16'd1; exp2 = 16'd2;
`else
        exp1 = 16'd0; exp2 = 16'd0;
`endif
        in_page[0] = 8'h30; in_page[1] = 8'h35; in_page[2] = 8'h3F;
        do_cmd(2'b01, 4'd2, 8'h2F, 8'h11, rd, st, lat, bc);
        do_cmd(2'b01, 4'd2, 8'h40, 8'h22, rd, st, lat, bc);
        do_cmd(2'b01, 4'd2, 8'h30, 8'h33, rd, st, lat, bc);
        do_cmd(2'b01, 4'd2, 8'h3F, 8'h44, rd, st, lat, bc);
        do_cmd(2'b10, 4'd2, 8'h37, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL erase_status: got %b want 00", st); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL erase_latency: got %0d want 16", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL erase_busy_cycles: got %0d want 16", bc); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL erase_ready_with_rsp: got %b want 1", cmd_ready); end
        checks++; if (erase_cnt !== exp1) begin errors++; $display("FAIL erase_cnt_first: got %0d want %0d", erase_cnt, exp1); end
        for (int i = 0; i < 3; i++) begin
            do_cmd(2'b00, 4'd2, in_page[i], 8'h00, rd, st, lat, bc);
            checks++; if (st !== 2'b01 || rd !== 8'hFF) begin errors++; $display("FAIL erased_word_%h: got %b/%h want 01/ff", in_page[i], st, rd); end
        end
        do_cmd(2'b00, 4'd2, 8'h2F, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00 || rd !== 8'h11) begin errors++; $display("FAIL below_page: got %b/%h want 00/11", st, rd); end
        do_cmd(2'b00, 4'd2, 8'h40, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00 || rd !== 8'h22) begin errors++; $display("FAIL above_page: got %b/%h want 00/22", st, rd); end
        do_cmd(2'b00, 4'd4, 8'hFF, 8'h00, rd, st, lat, bc);
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL other_pid_after_erase: got %h want 5a", rd); end
        do_cmd(2'b10, 4'd2, 8'h30, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL reerase_status: got %b want 00", st); end
        checks++; if (erase_cnt !== exp2) begin errors++; $display("FAIL erase_cnt_second: got %0d want %0d", erase_cnt, exp2); end
        do_cmd(2'b01, 4'd2, 8'h35, 8'h3C, rd, st, lat, bc);
        checks++; if (st !== 2'b00) begin errors++; $display("FAIL write_after_erase: got %b want 00", st); end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        do_cmd(2'b00, 4'd5, 8'h2F, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b11 || rd !== 8'h00) begin errors++; $display("FAIL bad_pid: got %b/%h want 11/00", st, rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL bad_pid_latency: got %0d want 1", lat); end
        do_cmd(2'b11, 4'd2, 8'h2F, 8'h77, rd, st, lat, bc);
        checks++; if (st !== 2'b11) begin errors++; $display("FAIL bad_op: got %b want 11", st); end
        do_cmd(2'b00, 4'd2, 8'h2F, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b00 || rd !== 8'h11) begin errors++; $display("FAIL bad_op_no_change: got %b/%h want 00/11", st, rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic [1:0] st; int lat; int bc;
        int ready_hi; int pulses; int lat_e;
        // Erase with cmd_valid held and a write queued behind it.
        cmd_op = 2'b10; cmd_pid = 4'd1; cmd_addr = 8'h00; cmd_wdata = 8'h00; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_addr = 8'h05; cmd_wdata = 8'h77;
        ready_hi = 0; lat_e = -1;
        for (int e = 1; e <= 40; e++) begin
            if (cmd_ready) ready_hi++;
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat_e = e;
                break;
            end
        end
        checks++; if (ready_hi !== 0) begin errors++; $display("FAIL ready_low_while_busy: got %0d ready cycles want 0", ready_hi); end
        checks++; if (lat_e !== 16) begin errors++; $display("FAIL held_erase_latency: got %0d want 16", lat_e); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin errors++; $display("FAIL queued_write_rsp: got %b/%b want 1/00", rsp_valid, rsp_status); end
        do_cmd(2'b00, 4'd1, 8'h05, 8'h00, rd, st, lat, bc);
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL queued_write_data: got %h want 77", rd); end
        // Held reads: one response every two cycles.
        cmd_op = 2'b00; cmd_pid = 4'd1; cmd_addr = 8'h05; cmd_valid = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        cmd_valid = 1'b0;
        checks++; if (pulses !== 4) begin errors++; $display("FAIL read_throughput: got %0d pulses want 4", pulses); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_erase();
        logic [7:0] rd; logic [1:0] st; int lat; int bc; int stray;
        do_cmd(2'b01, 4'd0, 8'h03, 8'h12, rd, st, lat, bc);
        cmd_op = 2'b10; cmd_pid = 4'd0; cmd_addr = 8'h00; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort_ready: got %b/%b want 1/0", cmd_ready, busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rst_no_response: got %0d pulses want 0", stray); end
        do_cmd(2'b00, 4'd0, 8'h03, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b01 || rd !== 8'hFF) begin errors++; $display("FAIL rst_clears_pid0: got %b/%h want 01/ff", st, rd); end
        do_cmd(2'b00, 4'd2, 8'h2F, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL rst_clears_pid2: got %b want 01", st); end
        do_cmd(2'b00, 4'd4, 8'hFF, 8'h00, rd, st, lat, bc);
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL rst_clears_pid4: got %b want 01", st); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_erased();
        test_write_read();
        test_double_write();
        test_erase();
        test_bad_cmd();
        test_back_to_back();
        test_reset_mid_erase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
